imem_miss_server: RTL

Memory-side responder for instruction-cache line-miss requests. Accepts `req_valid_miss`/`req_info_miss` from the fetch stage's instruction cache, queues them, fetches each full line from the main-memory backend port, and returns one `rsp_valid_miss` pulse per request with line data, `rsp_thread_id`, and `rsp_bus_error`. Sits between `instruction_cache_mt` and main memory, completing the miss protocol the cache initiates.

---
 rtl/imem_miss_server_pkg.sv | 54 +++++
 rtl/imem_req_fifo.sv | 62 ++++++
 rtl/imem_miss_server.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/imem_miss_server_pkg.sv
// imem_miss_server shared types: request bundle, queue entry, FSM state.
// Line geometry and address widths used by the miss server and its FIFO.
package imem_miss_server_pkg;

   localparam int THR_PER_CORE       = 4;
   localparam int THR_PER_CORE_WIDTH = 2;
   localparam int PHY_ADDR_WIDTH     = 32;
   localparam int ICACHE_LINE_BYTES  = 16;
   localparam int ICACHE_LINE_WIDTH  = ICACHE_LINE_BYTES * 8;
   localparam int ICACHE_OFFSET_W    = $clog2(ICACHE_LINE_BYTES);

   typedef struct packed {
      logic [PHY_ADDR_WIDTH-1:0] addr;
      logic [31:0]               data;
      logic [3:0]                be;
      logic                      we;
   } memory_request_t;

   typedef struct packed {
      logic [PHY_ADDR_WIDTH-1:0]     addr;
      logic [THR_PER_CORE_WIDTH-1:0] tid;
   } imem_q_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_ERR
   } imem_srv_state_t;

   function automatic logic [PHY_ADDR_WIDTH-1:0] line_align(
      input logic [PHY_ADDR_WIDTH-1:0] a
   );
      return {a[PHY_ADDR_WIDTH-1:ICACHE_OFFSET_W],
              {ICACHE_OFFSET_W{1'b0}}};
   endfunction

   // Range test widened by one bit so base+size cannot wrap.
   function automatic logic addr_illegal(
      input logic [PHY_ADDR_WIDTH-1:0] a,
      input logic [PHY_ADDR_WIDTH-1:0] base,
      input logic [PHY_ADDR_WIDTH-1:0] size
   );
      logic [PHY_ADDR_WIDTH:0] x;
      logic [PHY_ADDR_WIDTH:0] lo;
      logic [PHY_ADDR_WIDTH:0] hi;
      x  = {1'b0, a};
      lo = {1'b0, base};
      hi = lo + {1'b0, size};
      return (x < lo) || (x >= hi);
   endfunction

endpackage

// File: rtl/imem_req_fifo.sv
// Synchronous FIFO for pending line-miss requests.
// Power-of-two depth, wrapping pointers, push accepted when full only with a pop.
module imem_req_fifo #(
   parameter  int DEPTH = 4,
   parameter  int W     = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty,
   output logic [AW:0]  o_count
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_cnt;
   logic          w_wr;
   logic          w_rd;

   assign o_full  = (r_cnt == FULL_CNT);
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_rdata = r_mem[r_rp];

   assign w_rd = i_pop & ~o_empty;
   assign w_wr = i_push & (~o_full | w_rd);

   always_ff @(posedge clock) begin
      if (w_wr) begin
         r_mem[r_wp] <= i_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + 1'b1;
         end
         if (w_rd) begin
            r_rp <= r_rp + 1'b1;
         end
         unique case ({w_wr, w_rd})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/imem_miss_server.sv
// Memory-side responder for I-cache line misses: queue, backend fetch, reply.
// Optional address range check when IMEM_BUS_ERROR_CHECK_EN is defined.
module imem_miss_server
   import imem_miss_server_pkg::*;
#(
   parameter int                        QDEPTH   = THR_PER_CORE,
   parameter logic [PHY_ADDR_WIDTH-1:0] MEM_BASE = '0,
   parameter logic [PHY_ADDR_WIDTH-1:0] MEM_SIZE = 32'h0010_0000
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req_valid_miss,
   input  memory_request_t               req_info_miss,
   input  logic [THR_PER_CORE_WIDTH-1:0] req_thread_id,
   output logic                          rsp_valid_miss,
   output logic [THR_PER_CORE_WIDTH-1:0] rsp_thread_id,
   output logic [ICACHE_LINE_WIDTH-1:0]  rsp_data_miss,
   output logic                          rsp_bus_error,
   output logic                          mm_req_valid,
   output logic [PHY_ADDR_WIDTH-1:0]     mm_req_addr,
   input  logic                          mm_rsp_valid,
   input  logic [ICACHE_LINE_WIDTH-1:0]  mm_rsp_data,
   output logic                          q_overflow
);

   localparam int QW = $bits(imem_q_entry_t);
   localparam int CW = $clog2(QDEPTH) + 1;

   imem_srv_state_t r_state;

   logic [THR_PER_CORE_WIDTH-1:0] r_tid;
   logic                          r_mm_valid;
   logic [PHY_ADDR_WIDTH-1:0]     r_mm_addr;
   logic                          r_rsp_valid;
   logic [THR_PER_CORE_WIDTH-1:0] r_rsp_tid;
   logic [ICACHE_LINE_WIDTH-1:0]  r_rsp_data;
   logic                          r_rsp_err;
   logic                          r_ovf;

   imem_q_entry_t w_push_ent;
   imem_q_entry_t w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic [CW-1:0] w_count;
   logic          w_chk_en;
   logic          w_illegal;
   logic          w_unused_ok;

   assign w_push_ent.addr = req_info_miss.addr;
   assign w_push_ent.tid  = req_thread_id;
   assign w_pop           = (r_state == S_IDLE) & ~w_empty;

   imem_req_fifo #(
      .DEPTH (QDEPTH),
      .W     (QW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .i_push  (req_valid_miss),
      .i_wdata (w_push_ent),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

`ifdef IMEM_BUS_ERROR_CHECK_EN
   assign w_chk_en = 1'b1;
`else
   assign w_chk_en = 1'b0;
`endif

   assign w_illegal = w_chk_en &
                      addr_illegal(w_head.addr, MEM_BASE, MEM_SIZE);

   assign w_unused_ok = ^{w_count, req_info_miss.data,
                          req_info_miss.be, req_info_miss.we};

   assign rsp_valid_miss = r_rsp_valid;
   assign rsp_thread_id  = r_rsp_tid;
   assign rsp_data_miss  = r_rsp_data;
   assign rsp_bus_error  = w_chk_en & r_rsp_err;
   assign mm_req_valid   = r_mm_valid;
   assign mm_req_addr    = r_mm_addr;
   assign q_overflow     = r_ovf;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ovf <= 1'b0;
      end else if (req_valid_miss & w_full & ~w_pop) begin
         r_ovf <= 1'b1;
      end
   end

   // Strobes default low; ERR raises its reply on the way back to IDLE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_tid       <= '0;
         r_mm_valid  <= 1'b0;
         r_mm_addr   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= '0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
      end else begin
         r_mm_valid  <= 1'b0;
         r_rsp_valid <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (!w_empty) begin
                  r_tid <= w_head.tid;
                  if (w_illegal) begin
                     r_state <= S_ERR;
                  end else begin
                     r_state    <= S_ISSUE;
                     r_mm_valid <= 1'b1;
                     r_mm_addr  <= line_align(w_head.addr);
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (mm_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_tid   <= r_tid;
                  r_rsp_data  <= mm_rsp_data;
                  r_rsp_err   <= 1'b0;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
            end
            S_ERR: begin
               r_rsp_valid <= 1'b1;
               r_rsp_tid   <= r_tid;
               r_rsp_data  <= '0;
               r_rsp_err   <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
